// File: rtl/gpi_pad_ctrl_pkg.sv
// Shared types and constants for the GPI pad sequencing controller.
package gpi_pad_pkg;

  localparam int unsigned STE_W = 2;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    SETTLE = 2'd1,
    ACTIVE = 2'd2
  } gpi_state_e;

  localparam logic [1:0] EDGE_NONE = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  // True when a level transition towards new_level is selected for reporting.
  function automatic logic edge_match(input logic [1:0] sel, input logic new_level);
    logic hit;
    hit = 1'b0;
    case (sel)
      EDGE_NONE: hit = 1'b0;
      EDGE_RISE: hit = new_level;
      EDGE_FALL: hit = ~new_level;
      EDGE_BOTH: hit = 1'b1;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/gpi_pad_ctrl_if.sv
// Edge-event handshake between the pad controller and its core-side consumer.
interface gpi_pad_ctrl_if;

  logic evt_valid_o;
  logic evt_rise_o;
  logic evt_ack_i;
  logic evt_ovf_o;
  logic ovf_clr_i;

  // Controller side: produces events.
  modport master (
    output evt_valid_o,
    output evt_rise_o,
    output evt_ovf_o,
    input  evt_ack_i,
    input  ovf_clr_i
  );

  // Consumer side: accepts events and clears overflow.
  modport slave (
    input  evt_valid_o,
    input  evt_rise_o,
    input  evt_ovf_o,
    output evt_ack_i,
    output ovf_clr_i
  );

endinterface

// File: rtl/gpi_pad_ctrl_sync.sv
// Multi-stage synchroniser with asynchronous reset and synchronous clear.
module gpi_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the input through the chain unless cleared.
  always_comb begin
    sync_d = '0;
    if (!clr_i) begin
      sync_d = {sync_q[STAGES-2:0], d_i};
    end
  end

  // Synchroniser flops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/gpi_pad_ctrl.sv
// Power sequencing, Schmitt-trigger settle, debounce and edge reporting for one GPI pad.
module gpi_pad_ctrl
  import gpi_pad_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned DBNC_W        = 8,
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [STE_W-1:0]  ste_cfg_i,
  input  logic [DBNC_W-1:0] dbnc_len_i,
  input  logic [1:0]        edge_sel_i,
  output logic              pad_ie_o,
  output logic [STE_W-1:0]  pad_ste_o,
  input  logic [1:0]        pad_di_i,
  output logic              ready_o,
  output logic              level_o,
  gpi_pad_ctrl_if.master    evt
);

  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

  gpi_state_e        state_q, state_d;
  logic [SET_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic [STE_W-1:0]  pad_ste_q, pad_ste_d;
  logic              pad_ie_q, pad_ie_d;
  logic              ready_q, ready_d;
  logic              level_q, level_d;
  logic [DBNC_W-1:0] dbnc_cnt_q, dbnc_cnt_d;
  logic              evt_valid_q, evt_valid_d;
  logic              evt_rise_q, evt_rise_d;
  logic              evt_ovf_q, evt_ovf_d;

  logic sync_s;
  logic sync_clr;
  logic deb_en;
  logic lvl_chg;
  logic new_evt;
  logic ovf_set;
  logic unused_di;

  assign unused_di = pad_di_i[1];
  assign sync_clr  = (state_q == OFF);

  gpi_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (sync_clr),
    .d_i   (pad_di_i[0]),
    .q_o   (sync_s)
  );

  // Receiver power/settle sequencing; disable overrides every other transition.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    pad_ste_d    = pad_ste_q;
    if (!en_i) begin
      state_d      = OFF;
      settle_cnt_d = '0;
    end else begin
      unique case (state_q)
        OFF: begin
          state_d      = SETTLE;
          pad_ste_d    = ste_cfg_i;
          settle_cnt_d = '0;
        end
        SETTLE: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            state_d = ACTIVE;
          end else begin
            settle_cnt_d = settle_cnt_q + SET_W'(1);
          end
        end
        ACTIVE: begin
          if (ste_cfg_i != pad_ste_q) begin
            state_d      = SETTLE;
            pad_ste_d    = ste_cfg_i;
            settle_cnt_d = '0;
          end
        end
        default: state_d = OFF;
      endcase
    end
    pad_ie_d = (state_d != OFF);
    ready_d  = (state_d == ACTIVE);
  end

  // Debounce qualifies only while staying in ACTIVE, so a leaving cycle holds level.
  always_comb begin
    deb_en     = (state_q == ACTIVE) && (state_d == ACTIVE);
    level_d    = level_q;
    dbnc_cnt_d = '0;
    lvl_chg    = 1'b0;
    if (!en_i) begin
      level_d = 1'b0;
    end else if (deb_en && (sync_s != level_q)) begin
      if (dbnc_cnt_q >= dbnc_len_i) begin
        level_d = sync_s;
        lvl_chg = 1'b1;
      end else begin
        dbnc_cnt_d = dbnc_cnt_q + DBNC_W'(1);
      end
    end
  end

  // Event handshake: an ack in the same cycle frees the slot for the new edge.
  always_comb begin
    new_evt     = lvl_chg && edge_match(edge_sel_i, level_d);
    evt_valid_d = evt_valid_q;
    evt_rise_d  = evt_rise_q;
    ovf_set     = 1'b0;
    if (new_evt) begin
      if (!evt_valid_q || evt.evt_ack_i) begin
        evt_valid_d = 1'b1;
        evt_rise_d  = level_d;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (evt.evt_ack_i) begin
      evt_valid_d = 1'b0;
    end
    evt_ovf_d = ovf_set | (evt_ovf_q & ~evt.ovf_clr_i);
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= OFF;
      settle_cnt_q <= '0;
      pad_ste_q    <= '0;
      pad_ie_q     <= 1'b0;
      ready_q      <= 1'b0;
      level_q      <= 1'b0;
      dbnc_cnt_q   <= '0;
      evt_valid_q  <= 1'b0;
      evt_rise_q   <= 1'b0;
      evt_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      pad_ste_q    <= pad_ste_d;
      pad_ie_q     <= pad_ie_d;
      ready_q      <= ready_d;
      level_q      <= level_d;
      dbnc_cnt_q   <= dbnc_cnt_d;
      evt_valid_q  <= evt_valid_d;
      evt_rise_q   <= evt_rise_d;
      evt_ovf_q    <= evt_ovf_d;
    end
  end

  assign pad_ie_o        = pad_ie_q;
  assign pad_ste_o       = pad_ste_q;
  assign ready_o         = ready_q;
  assign level_o         = level_q;
  assign evt.evt_valid_o = evt_valid_q;
  assign evt.evt_rise_o  = evt_rise_q;
  assign evt.evt_ovf_o   = evt_ovf_q;

endmodule

// File: tb/tb_gpi_pad_ctrl.sv
// Scoreboard bench for gpi_pad_ctrl: directed scenarios followed by random stimulus.
module tb_gpi_pad_ctrl;

  localparam int unsigned SYNC   = 2;
  localparam int unsigned DW     = 8;
  localparam int unsigned SETTLE = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [1:0]    ste_cfg;
  logic [DW-1:0] dbnc;
  logic [1:0]    edge_sel;
  logic [1:0]    pad_di;
  logic          ack;
  logic          clr;
  logic          pad_ie;
  logic [1:0]    pad_ste;
  logic          ready;
  logic          level;

  gpi_pad_ctrl_if evt_if ();
  assign evt_if.evt_ack_i = ack;
  assign evt_if.ovf_clr_i = clr;

  always #5 clk = ~clk;

  gpi_pad_ctrl #(
    .SYNC_STAGES   (SYNC),
    .DBNC_W        (DW),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .ste_cfg_i  (ste_cfg),
    .dbnc_len_i (dbnc),
    .edge_sel_i (edge_sel),
    .pad_ie_o   (pad_ie),
    .pad_ste_o  (pad_ste),
    .pad_di_i   (pad_di),
    .ready_o    (ready),
    .level_o    (level),
    .evt        (evt_if)
  );

  typedef struct packed {
    logic       ie;
    logic [1:0] ste;
    logic       rdy;
    logic       lvl;
    logic       v;
    logic       r;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e, mon_g;
  int   checks = 0;
  int   errors = 0;

  // Reference model: on/off, countdown of remaining settle edges, run-length of disagreeing samples.
  bit         m_on, m_ready, m_level, m_valid, m_rise, m_ovf;
  int         m_settle, m_run;
  logic [1:0] m_ste;
  bit         m_hist[$];

  task automatic model_step();
    bit   s;
    bit   new_evt;
    bit   ovf_set;
    exp_t e;
    new_evt = 1'b0;
    ovf_set = 1'b0;
    if (rst) begin
      m_on = 0; m_ready = 0; m_level = 0; m_valid = 0; m_rise = 0; m_ovf = 0;
      m_settle = 0; m_run = 0; m_ste = 2'b00;
      m_hist = {};
      for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
    end else begin
      s = m_hist[SYNC-1];
      if (m_on) begin
        m_hist.push_front(pad_di[0]);
        void'(m_hist.pop_back());
      end else begin
        foreach (m_hist[i]) m_hist[i] = 1'b0;
      end
      if (!en) begin
        m_on = 0; m_ready = 0; m_level = 0; m_run = 0;
      end else if (!m_on) begin
        m_on = 1; m_settle = SETTLE; m_ste = ste_cfg; m_run = 0;
      end else if (!m_ready) begin
        m_settle = m_settle - 1;
        m_ready  = (m_settle == 0);
      end else if (ste_cfg != m_ste) begin
        m_ready = 0; m_settle = SETTLE; m_ste = ste_cfg; m_run = 0;
      end else if (s == m_level) begin
        m_run = 0;
      end else begin
        m_run = m_run + 1;
        if (m_run > int'(dbnc)) begin
          m_level = s;
          m_run   = 0;
          new_evt = s ? edge_sel[0] : edge_sel[1];
        end
      end
      if (new_evt) begin
        if (!m_valid || ack) begin
          m_valid = 1; m_rise = m_level;
        end else begin
          ovf_set = 1;
        end
      end else if (ack) begin
        m_valid = 0;
      end
      if (ovf_set) m_ovf = 1;
      else if (clr) m_ovf = 0;
    end
    e.ie = m_on; e.ste = m_ste; e.rdy = m_ready; e.lvl = m_level;
    e.v = m_valid; e.r = m_rise; e.ovf = m_ovf;
    exp_q.push_back(e);
  endtask

  // One clock of stimulus: predict the response to the current inputs, then advance.
  task automatic cyc();
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, got, expv, $time);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 40) begin
      cyc();
      n++;
    end
  endtask

  // Monitor: the DUT presents its full output vector every cycle; compare with the oldest prediction.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_g.ie = pad_ie; mon_g.ste = pad_ste; mon_g.rdy = ready; mon_g.lvl = level;
      mon_g.v = evt_if.evt_valid_o; mon_g.r = evt_if.evt_rise_o; mon_g.ovf = evt_if.evt_ovf_o;
      checks++;
      if (mon_g !== mon_e) begin
        errors++;
        $display("FAIL sb_outputs at %0t got ie=%b ste=%b rdy=%b lvl=%b v=%b r=%b ovf=%b expected ie=%b ste=%b rdy=%b lvl=%b v=%b r=%b ovf=%b",
                 $time, mon_g.ie, mon_g.ste, mon_g.rdy, mon_g.lvl, mon_g.v, mon_g.r, mon_g.ovf,
                 mon_e.ie, mon_e.ste, mon_e.rdy, mon_e.lvl, mon_e.v, mon_e.r, mon_e.ovf);
      end
    end
  end

  initial begin
    int n;
    logic lvl_before;
    rst = 1; en = 1; ste_cfg = 2'b01; dbnc = 8'd3; edge_sel = 2'b11;
    pad_di = 2'b00; ack = 0; clr = 0;
    repeat (3) cyc();

    // Outputs stay cleared while reset is held with en high.
    chk("rst_ie", pad_ie, 0);
    chk("rst_ste", pad_ste, 0);
    chk("rst_ready", ready, 0);
    chk("rst_level", level, 0);
    chk("rst_valid", evt_if.evt_valid_o, 0);
    chk("rst_ovf", evt_if.evt_ovf_o, 0);

    rst = 0;
    cyc();
    chk("en_ie", pad_ie, 1);
    chk("en_ste", pad_ste, 1);
    chk("en_ready_low", ready, 0);
    wait_ready(n);
    chk("settle_edges", n, SETTLE);

    // Debounce length 3: level follows after capture edge + 5.
    pad_di = 2'b01;
    repeat (5) cyc();
    chk("dbnc_not_yet", level, 0);
    cyc();
    chk("dbnc_level", level, 1);
    chk("dbnc_evt", evt_if.evt_valid_o, 1);
    ack = 1; cyc(); ack = 0;

    // Three-cycle glitch is filtered.
    pad_di = 2'b10;
    repeat (3) cyc();
    pad_di = 2'b01;
    repeat (8) cyc();
    chk("glitch_level", level, 1);
    chk("glitch_noevt", evt_if.evt_valid_o, 0);

    // Rising then falling with no ack: rise kept, overflow set.
    dbnc = 8'd0;
    pad_di = 2'b00; repeat (4) cyc();
    ack = 1; cyc(); ack = 0;
    pad_di = 2'b01; repeat (4) cyc();
    pad_di = 2'b00; repeat (4) cyc();
    chk("ovf_valid", evt_if.evt_valid_o, 1);
    chk("ovf_rise_kept", evt_if.evt_rise_o, 1);
    chk("ovf_set", evt_if.evt_ovf_o, 1);
    ack = 1; cyc(); ack = 0;
    chk("ack_clears", evt_if.evt_valid_o, 0);

    // Ack coincides with a new falling edge: slot reused with new polarity.
    pad_di = 2'b01; repeat (4) cyc();
    pad_di = 2'b00; cyc(); cyc();
    ack = 1; cyc(); ack = 0;
    chk("ackevt_valid", evt_if.evt_valid_o, 1);
    chk("ackevt_rise", evt_if.evt_rise_o, 0);
    clr = 1; cyc(); clr = 0;
    chk("ovf_clr", evt_if.evt_ovf_o, 0);

    // STE change in ACTIVE re-enters settle without dropping IE.
    lvl_before = level;
    ste_cfg = 2'b10;
    cyc();
    chk("ste_ready_low", ready, 0);
    chk("ste_ie_held", pad_ie, 1);
    chk("ste_value", pad_ste, 2);
    wait_ready(n);
    chk("ste_settle_edges", n, SETTLE);
    chk("ste_level_held", level, lvl_before);

    // en drops with level high and an event pending.
    pad_di = 2'b01; repeat (4) cyc();
    chk("pre_drop_level", level, 1);
    en = 0; cyc();
    chk("drop_ie", pad_ie, 0);
    chk("drop_ready", ready, 0);
    chk("drop_level", level, 0);
    chk("drop_valid_kept", evt_if.evt_valid_o, 1);
    chk("drop_rise_kept", evt_if.evt_rise_o, 0);

    // Reset asserted mid-SETTLE acts immediately.
    en = 1; repeat (4) cyc();
    rst = 1; #1;
    chk("async_ie", pad_ie, 0);
    chk("async_ready", ready, 0);
    chk("async_ste", pad_ste, 0);
    chk("async_valid", evt_if.evt_valid_o, 0);
    cyc();
    rst = 0; cyc();
    wait_ready(n);
    chk("rst_resettle", n, SETTLE);

    // Overflow set and clear in the same cycle: set wins.
    repeat (6) cyc();
    chk("pre_ovf_pending", evt_if.evt_valid_o, 1);
    pad_di = 2'b00; cyc(); cyc();
    clr = 1; cyc(); clr = 0;
    chk("ovf_set_wins", evt_if.evt_ovf_o, 1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if (en) begin
        if ($urandom_range(0, 99) < 1) en = 0;
      end else if ($urandom_range(0, 99) < 20) begin
        en = 1;
      end
      if ($urandom_range(0, 99) < 2)  ste_cfg = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 12) pad_di[0] = ~pad_di[0];
      pad_di[1] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 4)  dbnc = DW'($urandom_range(0, 5));
      if ($urandom_range(0, 99) < 4)  edge_sel = 2'($urandom_range(0, 3));
      ack = ($urandom_range(0, 99) < 25);
      clr = ($urandom_range(0, 99) < 5);
      rst = ($urandom_range(0, 999) < 3);
      cyc();
    end
    rst = 0; ack = 0; clr = 0;
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
